// File: rtl/traffic_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : traffic_input_ctrl
// Brief    : Synchronises and debounces the raw sensor and button inputs, and
//            tracks normal/parade mode for the traffic-light controller.
// Revision : 1.0
// ============================================================================
module traffic_input_ctrl #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sens_a_raw,
    input  logic sens_b_raw,
    input  logic btn_p_raw,
    input  logic btn_r_raw,
    output logic TA,
    output logic TB,
    output logic M,
    output logic p_pulse,
    output logic r_pulse
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] c_cnt_max = CW'(DEB_CYCLES - 1);

    // Channel order: 0 = sensor A, 1 = sensor B, 2 = parade, 3 = release
    logic [3:0] w_raw;
    logic [3:0] w_deb;
    logic [3:2] w_rise;

    assign w_raw = {btn_r_raw, btn_p_raw, sens_b_raw, sens_a_raw};

    for (genvar g = 0; g < 4; g++) begin : g_chan
        logic          r_sync1;
        logic          r_sync2;
        logic          r_deb;
        logic [CW-1:0] r_cnt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_deb   <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_raw[g];
                r_sync2 <= r_sync1;
                // Any sample matching the current value discards progress
                if (r_sync2 == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_max) begin
                    r_deb <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_deb[g] = r_deb;

        if (g >= 2) begin : g_edge
            logic r_deb_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_deb_q <= 1'b0;
                end else begin
                    r_deb_q <= r_deb;
                end
            end

            assign w_rise[g] = r_deb & ~r_deb_q;
        end
    end

    assign TA      = w_deb[0];
    assign TB      = w_deb[1];
    assign p_pulse = w_rise[2];
    assign r_pulse = w_rise[3];

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        PARADE = 1'b1
    } mode_t;

    mode_t r_state;

    // Release wins over parade whenever both pulses coincide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= NORMAL;
        end else begin
            case (r_state)
                NORMAL: begin
                    if (p_pulse && !r_pulse) begin
                        r_state <= PARADE;
                    end
                end
                PARADE: begin
                    if (r_pulse) begin
                        r_state <= NORMAL;
                    end
                end
                default: r_state <= NORMAL;
            endcase
        end
    end

    assign M = (r_state == PARADE);

endmodule
`default_nettype wire

// File: doc/traffic_input_ctrl.md
Name: traffic_input_ctrl

Overview:
- Upstream conditioning stage for the intersection traffic-light controller.
- Takes asynchronous raw inputs: two street traffic sensors plus Parade (P) and Release (R) push-buttons.
- Produces clean, clock-synchronous TA, TB and M. The downstream light FSM consumes these directly.
- Contains per-input synchronisers, counter-based debouncers, button rising-edge detectors and a two-state Moore mode FSM (normal/parade).

Parameters:
- DEB_CYCLES, default 4: consecutive stable cycles required before a debounced value changes. Legal range 1..255. Counter width = clog2(DEB_CYCLES+1).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clock clk.
- sens_a_raw  in  1  raw street-A traffic sensor, asynchronous, 1 = car present.
- sens_b_raw  in  1  raw street-B traffic sensor, asynchronous.
- btn_p_raw  in  1  raw Parade button, asynchronous, 1 = pressed.
- btn_r_raw  in  1  raw Release button, asynchronous, 1 = pressed.
- TA  out  1  debounced street-A traffic, registered.
- TB  out  1  debounced street-B traffic, registered.
- M  out  1  parade mode active, registered Moore output.
- p_pulse  out  1  one-cycle Parade-press pulse (observability).
- r_pulse  out  1  one-cycle Release-press pulse (observability).

Behaviour:
- Reset (async, immediate):
  - All synchroniser flops, debounced values, debounce counters and edge-detect history registers go to 0.
  - Mode state goes to NORMAL.
  - TA = TB = M = p_pulse = r_pulse = 0 while reset is high and on the first cycle after release.
- Synchroniser: 2-flop chain per raw input. sync = raw delayed 2 rising edges.
- Debouncer, per input, identical instances:
  - Holds deb (reset 0) and cnt (reset 0).
  - Each edge with sync == deb: cnt <= 0.
  - Each edge with sync != deb and cnt < DEB_CYCLES-1: cnt <= cnt+1.
  - Each edge with sync != deb and cnt == DEB_CYCLES-1: deb <= sync, cnt <= 0.
  - A single-cycle glitch or any return to the old value clears cnt; no partial credit is kept.
  - Latency from a clean raw transition to the deb change = 2 + DEB_CYCLES rising edges.
  - Symmetric for 0->1 and 1->0.
- TA = deb(sens_a), TB = deb(sens_b). No further delay.
- Edge detect:
  - deb_q <= deb each edge, reset 0.
  - p_pulse = deb_p & ~deb_q_p, combinational from registers. Exactly 1 cycle wide per debounced press.
  - Holding the button produces no further pulses. Release produces no pulse.
  - r_pulse is identical for R.
  - A button held through reset release yields one pulse once debounced.
- Mode FSM, states NORMAL (0) and PARADE (1):
  - NORMAL -> PARADE when p_pulse=1 and r_pulse=0.
  - PARADE -> NORMAL when r_pulse=1.
  - p_pulse and r_pulse in the same cycle: next state NORMAL. Release has priority in both states.
  - Any other case: hold state.
  - Illegal/unknown encoding returns to NORMAL.
- M = 1 iff state == PARADE. M rises 1 edge after p_pulse. Raw-press-to-M latency = 3 + DEB_CYCLES edges.
- Reset mid-debounce or mid-parade: everything aborts immediately to reset values. No pulse is generated by the reset itself.
- TA/TB are independent of M. The downstream FSM is responsible for combining them.

Test Plan:
- (1) DEB_CYCLES=4. Reset 3 cycles, then sens_a_raw 0->1 held -> TA = 0 for 5 edges, TA = 1 at the 6th edge after the raw change; TB, M stay 0.
- (2) sens_b_raw pulses high for 3 cycles, then low -> TB never rises. Then a 1-cycle low glitch in a stable-high TB input restarts the count, and TB stays 1.
- (3) btn_p_raw held high 20 cycles -> exactly one p_pulse, 6 edges after the press. M = 1 one edge later and stays 1 after the button is released.
- (4) With M=1, press btn_r_raw -> one r_pulse, then M = 0 on the next edge. Pressing R again while NORMAL leaves M = 0.
- (5) btn_p_raw and btn_r_raw rise in the same cycle from NORMAL -> both pulses coincide and M stays 0. Repeat from PARADE -> M goes to 0.
- (6) Assert reset while M=1 and a TA debounce count is in progress -> TA, TB, M, pulses = 0 immediately (asynchronously). After release with raw inputs low, all outputs stay 0.
